// File: rtl/ysyx_22040088_lsu_if.sv
// Memory-side bus of the load/store unit: one request channel with a
// valid/ready handshake and one response channel qualified by rsp_valid.
interface ysyx_22040088_lsu_if #(
  parameter int XLEN = 64
);
  logic            bus_req_valid;
  logic            bus_req_ready;
  logic [XLEN-1:0] bus_req_addr;
  logic            bus_req_wen;
  logic [XLEN-1:0] bus_req_wdata;
  logic [7:0]      bus_req_wstrb;
  logic            bus_rsp_valid;
  logic [XLEN-1:0] bus_rsp_rdata;

  modport master (
    output bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_addr, bus_req_wen, bus_req_wdata, bus_req_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rsp_rdata
  );
endinterface

// File: rtl/ysyx_22040088_lsu.sv
// Load/store unit: turns one execute-stage request into a single aligned
// 8-byte bus transaction, then lane-selects and extends the load result.
module ysyx_22040088_lsu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mem_wen,
  input  logic [3:0]      mem_mask,
  input  logic [2:0]      sel_rfres,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            misalign,
  ysyx_22040088_lsu_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t          state_reg;
  logic            busy_reg;
  logic            done_reg;
  logic            misalign_reg;
  logic [XLEN-1:0] rdata_reg;
  logic            req_valid_reg;
  logic [XLEN-1:0] req_addr_reg;
  logic            req_wen_reg;
  logic [XLEN-1:0] req_wdata_reg;
  logic [7:0]      req_wstrb_reg;
  logic [2:0]      off_reg;
  logic [3:0]      mask_reg;
  logic [2:1]      ext_reg;

  logic            legal;
  logic [7:0]      size_strb;
  logic [XLEN-1:0] lane_data;
  logic [XLEN-1:0] load_ext;
  logic            sign_ext;

  // A non-one-hot size falls through the default and is reported like a misalignment.
  always_comb begin
    legal     = 1'b0;
    size_strb = 8'h00;
    case (mem_mask)
      4'b0001: begin size_strb = 8'hFF; legal = (addr[2:0] == 3'b000); end
      4'b0010: begin size_strb = 8'h0F; legal = (addr[1:0] == 2'b00);  end
      4'b0100: begin size_strb = 8'h03; legal = (addr[0] == 1'b0);     end
      4'b1000: begin size_strb = 8'h01; legal = 1'b1;                  end
      default: begin size_strb = 8'h00; legal = 1'b0;                  end
    endcase
  end

  // Only an explicit zero-extend request (bit2 set, bit1 clear) avoids sign extension.
  assign sign_ext  = !(ext_reg[2] && !ext_reg[1]);
  assign lane_data = bus.bus_rsp_rdata >> {off_reg, 3'b000};

  always_comb begin
    load_ext = lane_data;
    case (mask_reg)
      4'b0010: load_ext = {{(XLEN-32){sign_ext & lane_data[31]}}, lane_data[31:0]};
      4'b0100: load_ext = {{(XLEN-16){sign_ext & lane_data[15]}}, lane_data[15:0]};
      4'b1000: load_ext = {{(XLEN-8){sign_ext & lane_data[7]}},   lane_data[7:0]};
      default: load_ext = lane_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      misalign_reg  <= 1'b0;
      rdata_reg     <= '0;
      req_valid_reg <= 1'b0;
      req_addr_reg  <= '0;
      req_wen_reg   <= 1'b0;
      req_wdata_reg <= '0;
      req_wstrb_reg <= 8'h00;
      off_reg       <= 3'b000;
      mask_reg      <= 4'b0000;
      ext_reg       <= 2'b00;
    end else begin
      done_reg     <= 1'b0;
      misalign_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy_reg <= 1'b1;
            if (legal) begin
              state_reg     <= REQ;
              req_valid_reg <= 1'b1;
              req_addr_reg  <= {addr[XLEN-1:3], 3'b000};
              req_wen_reg   <= mem_wen;
              req_wdata_reg <= wdata << {addr[2:0], 3'b000};
              req_wstrb_reg <= mem_wen ? (size_strb << addr[2:0]) : 8'h00;
              off_reg       <= addr[2:0];
              mask_reg      <= mem_mask;
              ext_reg       <= sel_rfres[2:1];
            end else begin
              state_reg    <= RESP;
              done_reg     <= 1'b1;
              misalign_reg <= 1'b1;
              rdata_reg    <= '0;
            end
          end
        end
        REQ: begin
          if (bus.bus_req_ready) begin
            req_valid_reg <= 1'b0;
            state_reg     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.bus_rsp_valid) begin
            rdata_reg <= req_wen_reg ? '0 : load_ext;
            done_reg  <= 1'b1;
            state_reg <= RESP;
          end
        end
        RESP: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy              = busy_reg;
  assign done              = done_reg;
  assign misalign          = misalign_reg;
  assign rdata             = rdata_reg;
  assign bus.bus_req_valid = req_valid_reg;
  assign bus.bus_req_addr  = req_addr_reg;
  assign bus.bus_req_wen   = req_wen_reg;
  assign bus.bus_req_wdata = req_wdata_reg;
  assign bus.bus_req_wstrb = req_wstrb_reg;

endmodule

// File: tb/tb_ysyx_22040088_lsu.sv
// Randomized self-checking bench for the LSU against a byte-level reference model.
module tb_ysyx_22040088_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_wen = 1'b0;
  logic [3:0]  mem_mask = 4'b0000;
  logic [2:0]  sel_rfres = 3'b000;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic        busy, done, misalign;
  logic [63:0] rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ysyx_22040088_lsu_if #(.XLEN(64)) mif ();

  ysyx_22040088_lsu #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_wen   (mem_wen),
    .mem_mask  (mem_mask),
    .sel_rfres (sel_rfres),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .misalign  (misalign),
    .bus       (mif.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int size_bytes(input logic [3:0] m);
    case (m)
      4'b0001: return 8;
      4'b0010: return 4;
      4'b0100: return 2;
      4'b1000: return 1;
      default: return 0;
    endcase
  endfunction

  // Reference load: gather nb bytes starting at lane off, then extend byte-wise.
  function automatic logic [63:0] ref_load(input logic [63:0] rsp, input int off, input int nb,
                                           input logic [2:0] sel);
    logic [63:0] v;
    bit zext;
    v = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = rsp[8*(off+i) +: 8];
    zext = (sel == 3'b100) || (sel == 3'b101);
    if (nb < 8 && !zext && v[8*nb-1])
      for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input logic [63:0] ea, input logic ew, input logic [63:0] ed,
                         input logic [7:0] es);
    chk_eq("req_valid", mif.bus_req_valid, 1);
    chk_eq("req_addr",  mif.bus_req_addr,  ea);
    chk_eq("req_wen",   mif.bus_req_wen,   ew);
    chk_eq("req_wdata", mif.bus_req_wdata, ed);
    chk_eq("req_wstrb", mif.bus_req_wstrb, es);
    chk_eq("busy_req",  busy, 1);
    chk_eq("done_req",  done, 0);
  endtask

  task automatic run_txn(input logic t_wen, input logic [3:0] t_mask, input logic [2:0] t_sel,
                         input logic [63:0] t_addr, input logic [63:0] t_wdata,
                         input logic [63:0] t_rsp, input int rdly, input int n, input bit poke);
    int nb, off, s;
    bit ok;
    logic [63:0] e_addr, e_wdata, e_rdata;
    logic [7:0]  e_strb;
    nb  = size_bytes(t_mask);
    off = int'(t_addr[2:0]);
    ok  = (nb != 0) && (off % nb == 0);
    e_addr  = t_addr & ~64'h7;
    e_wdata = '0;
    e_strb  = 8'h00;
    for (int j = off; j < 8; j++) e_wdata[8*j +: 8] = t_wdata[8*(j-off) +: 8];
    if (t_wen) for (int j = 0; j < nb; j++) e_strb[off+j] = 1'b1;
    e_rdata = t_wen ? 64'h0 : ref_load(t_rsp, off, nb, t_sel);

    start = 1'b1; mem_wen = t_wen; mem_mask = t_mask; sel_rfres = t_sel;
    addr = t_addr; wdata = t_wdata; s = cyc;
    tick();
    start = 1'b0;
    addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    mem_wen = ~t_wen; mem_mask = 4'($urandom); sel_rfres = 3'($urandom);

    if (!ok) begin
      chk_eq("err_done", done, 1);
      chk_eq("err_misalign", misalign, 1);
      chk_eq("err_rdata", rdata, 0);
      chk_eq("err_no_req", mif.bus_req_valid, 0);
      chk_eq("err_busy", busy, 1);
      tick();
      chk_eq("err_done_clr", done, 0);
      chk_eq("err_busy_clr", busy, 0);
      $display("txn err  wen=%0d mask=%b addr=%h", t_wen, t_mask, t_addr);
      return;
    end

    for (int i = 0; i < rdly; i++) begin
      start = (poke && i == 0);
      mif.bus_rsp_valid = 1'($urandom);
      chk_req(e_addr, t_wen, e_wdata, e_strb);
      tick();
    end
    start = 1'b0;
    mif.bus_rsp_valid = 1'b0;
    chk_req(e_addr, t_wen, e_wdata, e_strb);
    mif.bus_req_ready = 1'b1;
    tick();
    mif.bus_req_ready = 1'b0;
    chk_eq("req_dropped", mif.bus_req_valid, 0);
    for (int i = 0; i < n; i++) begin
      chk_eq("wait_done", done, 0);
      chk_eq("wait_busy", busy, 1);
      tick();
    end
    mif.bus_rsp_valid = 1'b1;
    mif.bus_rsp_rdata = t_rsp;
    tick();
    mif.bus_rsp_valid = 1'b0;
    mif.bus_rsp_rdata = {$urandom, $urandom};
    chk_eq("done", done, 1);
    chk_eq("misalign", misalign, 0);
    chk_eq("rdata", rdata, e_rdata);
    chk_eq("latency", 64'(cyc - s), 64'(3 + rdly + n));
    chk_eq("busy_resp", busy, 1);
    tick();
    chk_eq("done_clr", done, 0);
    chk_eq("busy_clr", busy, 0);
    chk_eq("no_extra_req", mif.bus_req_valid, 0);
    $display("txn ok   wen=%0d mask=%b sel=%b addr=%h rdata=%h rdly=%0d n=%0d",
             t_wen, t_mask, t_sel, t_addr, e_rdata, rdly, n);
  endtask

  initial begin
    mif.bus_req_ready = 1'b0;
    mif.bus_rsp_valid = 1'b0;
    mif.bus_rsp_rdata = '0;
    #1;
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_misalign", misalign, 0);
    chk_eq("rst_rdata", rdata, 0);
    chk_eq("rst_valid", mif.bus_req_valid, 0);
    chk_eq("rst_wen", mif.bus_req_wen, 0);
    chk_eq("rst_wstrb", mif.bus_req_wstrb, 0);
    chk_eq("rst_addr", mif.bus_req_addr, 0);
    chk_eq("rst_wdata", mif.bus_req_wdata, 0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Directed cases: lb, lwu, sh, misaligned ld, slow ready with a poke, bad size
    run_txn(1'b0, 4'b1000, 3'b010, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 0, 1, 1'b0);
    run_txn(1'b0, 4'b0010, 3'b100, 64'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 1'b0);
    run_txn(1'b1, 4'b0100, 3'b000, 64'h8000_0006, 64'h1234, 64'hDEAD_BEEF_0000_0000, 0, 2, 1'b0);
    run_txn(1'b0, 4'b0001, 3'b000, 64'h8000_0004, 64'h0, 64'h0, 0, 0, 1'b0);
    run_txn(1'b0, 4'b0100, 3'b000, 64'h8000_0002, 64'h0, 64'h0000_0000_F00D_0000, 5, 1, 1'b1);
    run_txn(1'b1, 4'b0011, 3'b000, 64'h8000_0000, 64'h55, 64'h0, 0, 0, 1'b0);

    // Reset while waiting for the response; the late response must be dropped
    start = 1'b1; mem_wen = 1'b0; mem_mask = 4'b0010; sel_rfres = 3'b010;
    addr = 64'h8000_0010; wdata = 64'h0;
    tick();
    start = 1'b0;
    mif.bus_req_ready = 1'b1;
    tick();
    mif.bus_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_busy", busy, 0);
    chk_eq("arst_valid", mif.bus_req_valid, 0);
    chk_eq("arst_addr", mif.bus_req_addr, 0);
    chk_eq("arst_rdata", rdata, 0);
    tick();
    rst = 1'b0;
    mif.bus_rsp_valid = 1'b1;
    mif.bus_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mif.bus_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_eq("stale_done", done, 0);
      chk_eq("stale_busy", busy, 0);
      chk_eq("stale_valid", mif.bus_req_valid, 0);
      tick();
    end
    $display("txn rst  reset during WAIT");

    for (int k = 0; k < 200; k++) begin
      logic [3:0] m;
      logic [63:0] a;
      case ($urandom_range(0, 9))
        0, 1:    m = 4'b0001;
        2, 3:    m = 4'b0010;
        4, 5:    m = 4'b0100;
        6, 7:    m = 4'b1000;
        default: m = 4'($urandom);
      endcase
      a = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~3'(size_bytes(m) - 1);
      mif.bus_rsp_valid = 1'($urandom);
      tick();
      chk_eq("idle_rsp_ignored", done, 0);
      mif.bus_rsp_valid = 1'b0;
      run_txn(1'($urandom), m, 3'($urandom), a, {$urandom, $urandom}, {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_22040088_lsu.md
YSYX_22040088_LSU -- requirements
Module: ysyx_22040088_lsu

Interface
REQ-001 Parameter: XLEN, 64, data and address width.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  one-cycle request from execute stage; sampled only in IDLE.
REQ-006 mem_wen  input  1  1 = store, 0 = load.
REQ-007 mem_mask  input  4  one-hot size from control unit: 0001 dword, 0010 word, 0100 half, 1000 byte.
REQ-008 sel_rfres  input  3  load extension: bit1 = sign-extend, bit2 = zero-extend.
REQ-009 addr  input  XLEN  byte address (ALU result).
REQ-010 wdata  input  XLEN  store data (rs2), right-aligned.
REQ-011 busy  output  1  high from the cycle after an accepted start until done.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 rdata  output  XLEN  extended load result; valid while done=1.
REQ-014 misalign  output  1  one-cycle pulse with done when the access was misaligned.
REQ-015 bus_req_valid  output  1  memory request valid.
REQ-016 bus_req_ready  input  1  memory accepts request.
REQ-017 bus_req_addr  output  XLEN  addr with bits[2:0] forced to 0.
REQ-018 bus_req_wen  output  1  write request.
REQ-019 bus_req_wdata  output  XLEN  wdata shifted left by 8*addr[2:0].
REQ-020 bus_req_wstrb  output  8  byte enables: size-mask shifted left by addr[2:0]; 0 for loads.
REQ-021 bus_rsp_valid  input  1  response/write-ack valid.
REQ-022 bus_rsp_rdata  input  XLEN  aligned 8-byte read data.

Function
REQ-023 FSM states: IDLE, REQ, WAIT, RESP; encoding is implementation choice.
REQ-024 IDLE: start=1 with an aligned access latches addr, wdata, mem_wen, mem_mask, and sel_rfres, then moves to REQ.
REQ-025 Alignment: dword needs addr[2:0]=0, word addr[1:0]=0, half addr[0]=0, byte any.
REQ-026 IDLE: start=1 with a misaligned access moves to RESP with no bus request; done=1, misalign=1, rdata=0 next cycle.
REQ-027 REQ: bus_req_valid=1, with all bus_req_* fields stable until handshake; valid&ready moves to WAIT.
REQ-028 bus_req_valid never deasserts before ready, except on reset.
REQ-029 WAIT: bus_rsp_valid=1 moves to RESP; for loads, rdata_reg takes the byte-lane-selected, extended bus_rsp_rdata.
REQ-030 Load extract: bus_rsp_rdata >> 8*addr[2:0], truncated to the size, then sign- or zero-extended to XLEN per sel_rfres.
REQ-031 sel_rfres 000 or 110 with a load: treat as sign-extend.
REQ-032 A dword load ignores extension.
REQ-033 Stores: rdata=0 at done.
REQ-034 RESP: done=1 for exactly one cycle, then return to IDLE.
REQ-035 Latency with ready=1 in REQ and response N cycles after the handshake: done arrives at 3+N cycles after start.
REQ-036 start while busy (not IDLE) is ignored.
REQ-037 bus_rsp_valid in IDLE, REQ, or RESP is ignored.
REQ-038 mem_mask not one-hot on start: no bus request, done+misalign pulse (illegal-size error).
REQ-039 busy=1 in REQ, WAIT, and RESP; 0 in IDLE.

Reset
REQ-040 rst=1 forces IDLE immediately: busy, done, misalign, bus_req_valid, bus_req_wen, bus_req_wstrb=0; rdata, bus_req_addr, bus_req_wdata=0.
REQ-041 Reset mid-REQ or mid-WAIT abandons the transaction; a stale response after reset is dropped.

Verification
REQ-042 lb at addr 0x8000_0003, rsp_rdata 0x0000_0000_8000_0000 -> bus_req_addr 0x8000_0000, wstrb 0, rdata 0xFFFF_FFFF_FFFF_FF80, done at cycle 4 (N=1).
REQ-043 lwu at 0x...04, rsp_rdata 0x8765_4321_0000_0000 -> rdata 0x0000_0000_8765_4321.
REQ-044 sh wdata 0x1234 at 0x...06 -> wstrb 8'b1100_0000, wdata 0x1234_0000_0000_0000, rdata 0.
REQ-045 ld at 0x...04 -> no bus_req_valid, done=1 and misalign=1 on cycle after start.
REQ-046 ready held low 5 cycles -> req fields stable throughout; second start during busy ignored.
REQ-047 rst asserted in WAIT, then rsp_valid -> outputs zero, state IDLE, no done pulse.
